// File: rtl/elastic_delay_if.sv
// Handshake bundle for elastic_delay: upstream push port, downstream pop port,
// flush control and occupancy readout.
interface elastic_delay_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    count;

  modport slave (
    input  flush, in_valid, in, out_ready,
    output in_ready, out_valid, out, count
  );

  modport master (
    output flush, in_valid, in, out_ready,
    input  in_ready, out_valid, out, count
  );
endinterface

// File: rtl/elastic_delay.sv
// DEPTH-stage valid/ready delay line; empty stages let words slide forward so a
// downstream stall only backs up to the first bubble.
module elastic_delay_stage #(
  parameter int WIDTH = 32,
  parameter int SAFE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ld,
  input  logic             prev_v,
  input  logic [WIDTH-1:0] prev_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  localparam logic [WIDTH-1:0] RST_D = (SAFE != 0) ? '0 : 'x;

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      d <= RST_D;
    end else if (flush) begin
      v <= 1'b0;
    end else if (ld) begin
      v <= prev_v;
      // a bubble moving in leaves the old data in place
      if (prev_v) d <= prev_d;
    end
  end
endmodule

module elastic_delay #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SAFE  = 0
) (
  input  logic           clk,
  input  logic           reset,
  elastic_delay_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("elastic_delay: DEPTH must be >= 1");
  end

  // index 0 is the upstream port, index i+1 is stage i
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            rdy;
  logic [CW-1:0]             count_q;
  logic                      accept, consume;

  assign vld_pipe[0] = bus.in_valid;
  assign dat_pipe[0] = bus.in;
  assign rdy[DEPTH]  = bus.out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign rdy[i] = !vld_pipe[i+1] | rdy[i+1];

    elastic_delay_stage #(.WIDTH(WIDTH), .SAFE(SAFE)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .flush  (bus.flush),
      .ld     (rdy[i]),
      .prev_v (vld_pipe[i]),
      .prev_d (dat_pipe[i]),
      .v      (vld_pipe[i+1]),
      .d      (dat_pipe[i+1])
    );
  end

  assign bus.in_ready  = rdy[0] & !bus.flush;
  assign bus.out_valid = vld_pipe[DEPTH];
  assign bus.out       = dat_pipe[DEPTH];
  assign bus.count     = count_q;

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) count_q <= '0;
    else                    count_q <= count_q + CW'(accept) - CW'(consume);
  end
endmodule

// File: tb/tb_elastic_delay.sv
// Bench for elastic_delay (WIDTH=32, DEPTH=4, SAFE=1): per-cycle vector table plus
// a scoreboard queue that tracks accepted words and expected occupancy.
module tb_elastic_delay;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  elastic_delay_if #(.WIDTH(32), .DEPTH(4)) bus ();

  elastic_delay #(.WIDTH(32), .DEPTH(4), .SAFE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // scoreboard: handshakes are decided by the values stable at the falling edge
  logic [31:0] sb[$];
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      check("count_vs_model", 32'(bus.count), 32'(sb.size()));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_out", bus.out, 32'hDEAD_DEAD);
        else check("sb_out", bus.out, sb.pop_front());
      end
      if (bus.flush) begin
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
      end else if (bus.in_valid && bus.in_ready) sb.push_back(bus.in);
    end
  end

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    @(posedge clk); #1;
    bus.flush = fl; bus.in_valid = iv; bus.in = d; bus.out_ready = ordy;
    @(negedge clk);
  endtask

  typedef struct {
    logic        fl, iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_out;
    int          e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [31:0] e_out, input int e_cnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_out = e_out; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;

    // reset state, then fill/stall/drain
    add(0,0,32'h0 ,0, 1,0,32'h0 ,0);
    add(0,1,32'h11,0, 1,0,32'h0 ,0);
    add(0,1,32'h22,0, 1,0,32'h0 ,1);
    add(0,1,32'h33,0, 1,0,32'h0 ,2);
    add(0,1,32'h44,0, 1,0,32'h0 ,3);
    for (int i = 0; i < 5; i++) add(0,1,32'hBAD,0, 0,1,32'h11,4);
    add(0,0,32'h0 ,1, 1,1,32'h11,4);
    add(0,0,32'h0 ,1, 1,1,32'h22,3);
    add(0,0,32'h0 ,1, 1,1,32'h33,2);
    add(0,0,32'h0 ,1, 1,1,32'h44,1);
    add(0,0,32'h0 ,0, 1,0,32'h44,0);
    // bubbles collapse against a stalled head
    add(0,1,32'h55,0, 1,0,32'h44,0);
    add(0,0,32'h0 ,0, 1,0,32'h44,1);
    add(0,0,32'h0 ,0, 1,0,32'h44,1);
    add(0,1,32'h66,0, 1,0,32'h44,1);
    add(0,0,32'h0 ,0, 1,1,32'h55,2);
    add(0,0,32'h0 ,0, 1,1,32'h55,2);
    add(0,0,32'h0 ,0, 1,1,32'h55,2);
    add(0,0,32'h0 ,1, 1,1,32'h55,2);
    add(0,0,32'h0 ,1, 1,1,32'h66,1);
    add(0,0,32'h0 ,0, 1,0,32'h66,0);
    // full pipe: simultaneous accept and consume
    add(0,1,32'hC1,0, 1,0,32'h66,0);
    add(0,1,32'hC2,0, 1,0,32'h66,1);
    add(0,1,32'hC3,0, 1,0,32'h66,2);
    add(0,1,32'hC4,0, 1,0,32'h66,3);
    add(0,1,32'h77,1, 1,1,32'hC1,4);
    add(0,0,32'h0 ,0, 0,1,32'hC2,4);
    add(0,0,32'h0 ,1, 1,1,32'hC2,4);
    add(0,0,32'h0 ,1, 1,1,32'hC3,3);
    add(0,0,32'h0 ,1, 1,1,32'hC4,2);
    add(0,0,32'h0 ,1, 1,1,32'h77,1);
    add(0,0,32'h0 ,0, 1,0,32'h77,0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[r]) begin
      drive(tbl[r].fl, tbl[r].iv, tbl[r].d, tbl[r].ordy);
      check($sformatf("tbl%0d_in_ready", r),  32'(bus.in_ready),  32'(tbl[r].e_ir));
      check($sformatf("tbl%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].e_ov));
      check($sformatf("tbl%0d_out", r),       bus.out,            tbl[r].e_out);
      check($sformatf("tbl%0d_count", r),     32'(bus.count),     32'(tbl[r].e_cnt));
    end

    // streaming: latency DEPTH, one word per cycle, count steady at DEPTH
    for (int k = 0; k < 14; k++) begin
      drive(0, k < 8, 32'hA0 + 32'(k), 1);
      check($sformatf("stream%0d_out_valid", k), 32'(bus.out_valid), 32'(k >= 4 && k < 12));
      if (k >= 4 && k < 12) check($sformatf("stream%0d_out", k), bus.out, 32'hA0 + 32'(k - 4));
      if (k >= 4 && k < 8)  check($sformatf("stream%0d_count", k), 32'(bus.count), 32'd4);
    end

    // flush with three words in flight; the head is consumed during the flush cycle
    drive(0,1,32'hB1,0);
    drive(0,1,32'hB2,0);
    drive(0,1,32'hB3,0);
    drive(0,0,32'h0 ,0);
    drive(1,1,32'h99,1);
    check("flush_cycle_in_ready", 32'(bus.in_ready), 32'd0);
    check("flush_cycle_head", bus.out, 32'hB1);
    drive(0,0,32'h0,1);
    check("post_flush_count", 32'(bus.count), 32'd0);
    check("post_flush_out_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      drive(0,0,32'h0,1);
      check($sformatf("post_flush%0d_out_valid", k), 32'(bus.out_valid), 32'd0);
    end

    // reset mid-stream discards everything in flight
    drive(0,1,32'hE1,1);
    drive(0,1,32'hE2,1);
    drive(0,1,32'hE3,1);
    @(posedge clk); #1;
    reset = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out", bus.out, 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      drive(0,0,32'h0,1);
      check($sformatf("post_rst%0d_out_valid", k), 32'(bus.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
